// File: rtl/tisc_pkg.sv
// Shared register-file constants and the writeback queue entry type.
package tisc_pkg;
   localparam int REG_ADDR_W = 3;
   localparam int REG_DATA_W = 8;
   localparam int NUM_REGS   = 8;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [REG_DATA_W-1:0] data;
   } wb_entry_t;
endpackage

// File: rtl/wb_match.sv
// Associative lookup over the writeback queue: pending flag and, with
// REG_WRITEBACK_BYPASS_EN, the data of the youngest matching entry.
module wb_match
   import tisc_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  wb_entry_t             entries [DEPTH],
   input  logic [DEPTH-1:0]      occ,
   input  logic [PTR_W-1:0]      rd_ptr,
   input  logic [REG_ADDR_W-1:0] lk_addr,
`ifdef REG_WRITEBACK_BYPASS_EN
   output logic [REG_DATA_W-1:0] data,
`endif
   output logic                  hit
);

   always_comb begin
      hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (occ[i] && (entries[i].addr == lk_addr)) hit = 1'b1;
      end
   end

`ifdef REG_WRITEBACK_BYPASS_EN
   // Walk oldest to youngest so the last hit seen is the newest value.
   always_comb begin
      logic [PTR_W-1:0] idx;
      data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = rd_ptr + PTR_W'(i);
         if (occ[idx] && (entries[idx].addr == lk_addr)) data = entries[idx].data;
      end
   end
`else
   logic unused_bits;
   always_comb begin
      unused_bits = ^rd_ptr;
      for (int i = 0; i < DEPTH; i++) unused_bits = unused_bits ^ (^entries[i].data);
   end
`endif

endmodule

// File: rtl/reg_writeback.sv
// In-order writeback queue feeding the register file write port, with decode
// lookups. Optional value bypass via REG_WRITEBACK_BYPASS_EN.
module reg_writeback
   import tisc_pkg::*;
#(
   parameter  int DEPTH  = 4,
   parameter  int ADDR_W = REG_ADDR_W,
   parameter  int DATA_W = REG_DATA_W,
   localparam int PTR_W  = $clog2(DEPTH),
   localparam int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              res_valid,
   output logic              res_ready,
   input  logic [ADDR_W-1:0] res_addr,
   input  logic [DATA_W-1:0] res_data,
   input  logic              rf_hold,
   output logic              rf_en,
   output logic [ADDR_W-1:0] rf_write_addr,
   output logic [DATA_W-1:0] rf_write_data,
   input  logic [ADDR_W-1:0] lk_addr_1,
   input  logic [ADDR_W-1:0] lk_addr_2,
   output logic              lk_pend_1,
   output logic              lk_pend_2,
`ifdef REG_WRITEBACK_BYPASS_EN
   output logic [DATA_W-1:0] lk_data_1,
   output logic [DATA_W-1:0] lk_data_2,
`endif
   output logic [CNT_W-1:0]  count
);

   wb_entry_t        mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [DEPTH-1:0] occ;
   logic             push;
   logic             pop;
   logic             not_empty;
   wb_entry_t        head;

   // Full is judged on registered count only; a draining full queue still refuses.
   assign res_ready = (count != CNT_W'(DEPTH)) && rst_n;
   assign not_empty = (count != '0);
   assign rf_en     = not_empty && !rf_hold;
   assign push      = res_valid && res_ready;
   assign pop       = rf_en;
   assign head      = mem[rd_ptr];

   assign rf_write_addr = not_empty ? head.addr : '0;
   assign rf_write_data = not_empty ? head.data : '0;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= '{addr: res_addr, data: res_data};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // A slot is occupied when its distance from the head is below count.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         occ[i] = CNT_W'(PTR_W'(i) - rd_ptr) < count;
      end
   end

   wb_match #(.DEPTH(DEPTH)) u_match_1 (
      .entries (mem),
      .occ     (occ),
      .rd_ptr  (rd_ptr),
      .lk_addr (lk_addr_1),
`ifdef REG_WRITEBACK_BYPASS_EN
      .data    (lk_data_1),
`endif
      .hit     (lk_pend_1)
   );

   wb_match #(.DEPTH(DEPTH)) u_match_2 (
      .entries (mem),
      .occ     (occ),
      .rd_ptr  (rd_ptr),
      .lk_addr (lk_addr_2),
`ifdef REG_WRITEBACK_BYPASS_EN
      .data    (lk_data_2),
`endif
      .hit     (lk_pend_2)
   );

endmodule

// File: doc/reg_writeback.md
# reg_writeback

Write-side companion to the 8×8-bit register file. Accepts execute-stage results (destination address and data) over a valid/ready handshake and buffers them in a small in-order queue. Drains one entry per cycle onto the register file write port (EN, write_addr, write_data). Answers two decode-stage lookups that report whether a register still has a write pending and, optionally, its newest pending value.

## Interface
Parameters:
- DEPTH, 4, queue entries; power of two, ≥ 2
- ADDR_W, 3, register address width (8 registers)
- DATA_W, 8, register data width

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- res_valid  in  1  execute result present
- res_ready  out  1  queue can accept a result
- res_addr  in  ADDR_W  destination register
- res_data  in  DATA_W  result value
- rf_hold  in  1  register file write port unavailable this cycle
- rf_en  out  1  write enable to register file EN
- rf_write_addr  out  ADDR_W  to register file write_addr
- rf_write_data  out  DATA_W  to register file write_data
- lk_addr_1, lk_addr_2  in  ADDR_W  decode operand addresses
- lk_pend_1, lk_pend_2  out  1  a queued write targets that address
- lk_data_1, lk_data_2  out  DATA_W  newest queued value for that address (bypass build only)
- count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Storage: circular buffer of DEPTH entries {addr, data}; wr_ptr, rd_ptr, count.
- Push: res_valid && res_ready at a rising edge writes the entry at wr_ptr and advances wr_ptr modulo DEPTH.
- res_ready = (count != DEPTH) && rst_n. There is no combinational path from rf_hold or the pop condition, so a full queue never accepts a result, even in a cycle where it drains.
- Drain: rf_en = (count != 0) && !rf_hold; rf_write_addr and rf_write_data = head entry. When rf_en is high, the edge pops the head and advances rd_ptr modulo DEPTH.
- When count == 0, rf_write_addr and rf_write_data are 0.
- Push and pop at the same edge: count unchanged; both pointers advance.
- Lookup (combinational): compare lk_addr_n against every occupied entry. lk_pend_n = any match. lk_data_n = data of the youngest match (closest to wr_ptr), or 0 if none.
- The entry being drained in the current cycle still counts as pending.
- Results offered in the current cycle but not yet accepted are not visible to lookup.
- Address 0 has no special treatment.
- Writes to the same address drain in arrival order, so the last write wins in the register file.
- Reset (asynchronous, any time): pointers and count go to 0, rf_en deasserts immediately, and all pending entries are discarded; the register file keeps whatever it already holds.

## Timing
- Reset values: res_ready 0 while rst_n low, 1 from the first cycle after release; rf_en 0; rf_write_addr 0; rf_write_data 0; lk_pend_n 0; lk_data_n 0; count 0.
- Latency: a result accepted at edge k appears on rf_* in the cycle after k (if rf_hold is low) and is written to the register file at edge k+1.
- Throughput: one push and one pop per cycle in steady state.
- rf_hold high: head entry and rf_* values are held stable and rf_en is low; the queue may fill.
- count, lk_pend_n and lk_data_n reflect the contents after the previous edge.

## Configuration
- Macro: REG_WRITEBACK_BYPASS_EN.
- Defined: lk_data_1 and lk_data_2 exist and carry the youngest matching data, so decode can forward the value.
- Undefined: lk_data ports and the youngest-match priority logic are omitted; only lk_pend_n is produced, and decode stalls on pending operands.
- All other behaviour is identical in both builds.

## Structure
- Shared package tisc_pkg: REG_ADDR_W = 3, REG_DATA_W = 8, NUM_REGS = 8, and the wb_entry_t struct {addr, data}. The parameter defaults come from these constants.
- Sub-module wb_match: one instance per lookup port. Inputs are the entry array, an occupancy mask and rd_ptr; outputs are the hit flag and the youngest data.
- The queue and pointer logic stay in reg_writeback.

## Test plan
- Reset, then push {addr 3, data 0x5A} with rf_hold low -> rf_en high for exactly one cycle with addr 3 / 0x5A at the next cycle; count returns to 0.
- Hold rf_hold high and offer 5 results -> 4 accepted, res_ready low with count 4; release rf_hold -> 4 writes drain in order, one per cycle.
- Queue {2, 0x11}, then {2, 0x22}, with hold high; lk_addr_1 = 2 -> lk_pend_1 = 1 and lk_data_1 = 0x22 (bypass build); drain order is 0x11 then 0x22.
- Full queue, rf_hold low, res_valid high -> no accept in that cycle; accepted the following cycle; count stays ≤ 4 throughout.
- Pointer wrap: stream 10 back-to-back results with hold low -> every result written exactly once, in order, with count ≤ 1.
- Assert rst_n low with 3 entries queued -> rf_en, count and lk_pend_n drop to 0 immediately; after release, no stale writes appear.
